mips_mem_arbiter: RTL and testbench

- Shares the single memory port of synth_dual_port_memory between two requesters.
- Requester 0 is the mips_multicycle_vn core. Requester 1 is an auxiliary master: program loader, DMA or debug port.
- Arbitration is round-robin with a bounded burst length per requester, so neither side starves.
- Read data returns to the requester that issued it, after a fixed memory latency.

---
 rtl/mips_mem_arbiter_pkg.sv | 21 ++
 rtl/mips_mem_arbiter_if.sv | 54 +++++
 rtl/mips_mem_rd_tag_pipe.sv | 27 ++
 rtl/mips_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mips_mem_arbiter.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_arbiter_pkg.sv
// Shared constants and types for the two-port memory arbiter.
// Port indices double as bit positions inside the one-hot read tag.
package mips_mem_arbiter_pkg;

  localparam int ARB_PORT_CORE  = 0;
  localparam int ARB_PORT_AUX   = 1;
  localparam int STAT_W         = 32;
  localparam int RD_LATENCY_MAX = 4;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_AUX  = 1'b1
  } arb_port_e;

  typedef logic [1:0] rd_tag_t;

  function automatic logic [STAT_W-1:0] stat_sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters and the memory port.
// master = arbiter side, slave = requesters plus memory.
interface mips_mem_arbiter_if
  import mips_mem_arbiter_pkg::*;
#(
  parameter int N = 32
);

  logic              req0;
  logic [N-1:0]      addr0;
  logic              wr_ena0;
  logic [N-1:0]      wr_data0;
  logic              gnt0;
  logic              rd_valid0;
  logic [N-1:0]      rd_data0;

  logic              req1;
  logic [N-1:0]      addr1;
  logic              wr_ena1;
  logic [N-1:0]      wr_data1;
  logic              gnt1;
  logic              rd_valid1;
  logic [N-1:0]      rd_data1;

  logic [N-1:0]      mem_addr;
  logic [N-1:0]      mem_wr_data;
  logic              mem_wr_ena;
  logic [N-1:0]      mem_rd_data;

  logic [STAT_W-1:0] stat_gnt0;
  logic [STAT_W-1:0] stat_gnt1;
  logic [STAT_W-1:0] stat_conflict;

  modport master (
    input  req0, addr0, wr_ena0, wr_data0,
    input  req1, addr1, wr_ena1, wr_data1,
    input  mem_rd_data,
    output gnt0, rd_valid0, rd_data0,
    output gnt1, rd_valid1, rd_data1,
    output mem_addr, mem_wr_data, mem_wr_ena,
    output stat_gnt0, stat_gnt1, stat_conflict
  );

  modport slave (
    output req0, addr0, wr_ena0, wr_data0,
    output req1, addr1, wr_ena1, wr_data1,
    output mem_rd_data,
    input  gnt0, rd_valid0, rd_data0,
    input  gnt1, rd_valid1, rd_data1,
    input  mem_addr, mem_wr_data, mem_wr_ena,
    input  stat_gnt0, stat_gnt1, stat_conflict
  );

endinterface

// File: rtl/mips_mem_rd_tag_pipe.sv
// DEPTH-stage shift register carrying the one-hot owner tag of each read,
// aligned with the memory read latency; asynchronous clear drops in-flight reads.
module mips_mem_rd_tag_pipe
  import mips_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    rst,
  input  rd_tag_t i_tag,
  output rd_tag_t o_tag
);

  rd_tag_t r_tag_p [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_tag_p[i] <= '0;
    end else begin
      r_tag_p[0] <= i_tag;
      for (int i = 1; i < DEPTH; i++) r_tag_p[i] <= r_tag_p[i-1];
    end
  end

  assign o_tag = r_tag_p[DEPTH-1];

endmodule

// File: rtl/mips_mem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one memory port between the core (port 0)
// and an auxiliary master (port 1). Grant counters are built only with MIPS_MEM_ARB_STATS_EN.
module mips_mem_arbiter
  import mips_mem_arbiter_pkg::*;
#(
  parameter int N          = 32,
  parameter int MAX_BURST  = 4,
  parameter int RD_LATENCY = 1
) (
  input  logic               clk,
  input  logic               rst,
  mips_mem_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

  if (MAX_BURST < 1) begin : g_bad_burst
    $error("MAX_BURST must be at least 1");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $error("RD_LATENCY out of range 1..4");
  end

  arb_port_e        r_last_owner;
  logic [CNT_W-1:0] r_run_cnt;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_keep_owner;
  arb_port_e        w_gnt_port;
  rd_tag_t          w_tag_in;
  rd_tag_t          w_tag_out;
  logic [N-1:0]     w_mem_addr;
  logic [N-1:0]     w_mem_wr_data;
  logic             w_mem_wr_ena;

  // Grant is held off during reset so nothing reaches memory while rst is high
  always_comb begin
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_keep_owner = (r_run_cnt < BURST_LIM);
    if (!rst) begin
      if (bus.req0 && bus.req1) begin
        if (w_keep_owner) begin
          w_gnt0 = (r_last_owner == PORT_CORE);
          w_gnt1 = (r_last_owner == PORT_AUX);
        end else begin
          w_gnt0 = (r_last_owner == PORT_AUX);
          w_gnt1 = (r_last_owner == PORT_CORE);
        end
      end else begin
        w_gnt0 = bus.req0;
        w_gnt1 = bus.req1;
      end
    end
  end

  assign w_gnt_port = w_gnt1 ? PORT_AUX : PORT_CORE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_owner <= PORT_CORE;
      r_run_cnt    <= '0;
    end else if (!(w_gnt0 || w_gnt1)) begin
      r_run_cnt    <= '0;
    end else if (w_gnt_port == r_last_owner) begin
      r_run_cnt    <= (r_run_cnt == BURST_LIM) ? r_run_cnt : r_run_cnt + 1'b1;
    end else begin
      r_last_owner <= w_gnt_port;
      r_run_cnt    <= CNT_W'(1);
    end
  end

  always_comb begin
    w_mem_addr    = '0;
    w_mem_wr_data = '0;
    w_mem_wr_ena  = 1'b0;
    if (w_gnt0) begin
      w_mem_addr    = bus.addr0;
      w_mem_wr_data = bus.wr_data0;
      w_mem_wr_ena  = bus.wr_ena0;
    end else if (w_gnt1) begin
      w_mem_addr    = bus.addr1;
      w_mem_wr_data = bus.wr_data1;
      w_mem_wr_ena  = bus.wr_ena1;
    end
  end

  assign bus.gnt0        = w_gnt0;
  assign bus.gnt1        = w_gnt1;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_wr_data = w_mem_wr_data;
  assign bus.mem_wr_ena  = w_mem_wr_ena;

  // Reads push their owner's one-hot tag; writes and idle cycles push zero
  assign w_tag_in[ARB_PORT_CORE] = w_gnt0 && !bus.wr_ena0;
  assign w_tag_in[ARB_PORT_AUX]  = w_gnt1 && !bus.wr_ena1;

  mips_mem_rd_tag_pipe #(
    .DEPTH (RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign bus.rd_valid0 = w_tag_out[ARB_PORT_CORE];
  assign bus.rd_valid1 = w_tag_out[ARB_PORT_AUX];
  assign bus.rd_data0  = w_tag_out[ARB_PORT_CORE] ? bus.mem_rd_data : '0;
  assign bus.rd_data1  = w_tag_out[ARB_PORT_AUX]  ? bus.mem_rd_data : '0;

`ifdef MIPS_MEM_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat_gnt0;
  logic [STAT_W-1:0] r_stat_gnt1;
  logic [STAT_W-1:0] r_stat_conflict;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_gnt0     <= '0;
      r_stat_gnt1     <= '0;
      r_stat_conflict <= '0;
    end else begin
      if (w_gnt0) r_stat_gnt0 <= stat_sat_inc(r_stat_gnt0);
      if (w_gnt1) r_stat_gnt1 <= stat_sat_inc(r_stat_gnt1);
      if (bus.req0 && bus.req1) r_stat_conflict <= stat_sat_inc(r_stat_conflict);
    end
  end

  assign bus.stat_gnt0     = r_stat_gnt0;
  assign bus.stat_gnt1     = r_stat_gnt1;
  assign bus.stat_conflict = r_stat_conflict;
`else
  assign bus.stat_gnt0     = '0;
  assign bus.stat_gnt1     = '0;
  assign bus.stat_conflict = '0;
`endif

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: one instance at RD_LATENCY=1 with a small memory model,
// one at RD_LATENCY=3 with a constant read-data source for the reset-mid-read case.
module tb_mips_mem_arbiter;
  import mips_mem_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic rst_b;

  mips_mem_arbiter_if #(.N(32)) ba ();
  mips_mem_arbiter_if #(.N(32)) bb ();

  mips_mem_arbiter #(.N(32), .MAX_BURST(4), .RD_LATENCY(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ba)
  );

  mips_mem_arbiter #(.N(32), .MAX_BURST(4), .RD_LATENCY(3)) u_dut_lat3 (
    .clk (clk),
    .rst (rst_b),
    .bus (bb)
  );

  // One-cycle synchronous memory behind instance A, with a preload path
  logic [31:0] mem [256];
  logic [31:0] r_rd_q;
  logic        pl_we;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (ba.mem_wr_ena) mem[ba.mem_addr[7:0]] <= ba.mem_wr_data;
    r_rd_q <= mem[ba.mem_addr[7:0]];
  end

  assign ba.mem_rd_data = r_rd_q;
  assign bb.mem_rd_data = 32'hCAFE_F00D;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  logic [9:0]  cont_seq;
  logic [5:0]  gap_seq;
  logic        pg0, pg1;
  logic [31:0] exp_conf, exp_g0, exp_g1;

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    ba.req0 = 1'b0; ba.addr0 = '0; ba.wr_ena0 = 1'b0; ba.wr_data0 = '0;
    ba.req1 = 1'b0; ba.addr1 = '0; ba.wr_ena1 = 1'b0; ba.wr_data1 = '0;
    bb.req0 = 1'b0; bb.addr0 = '0; bb.wr_ena0 = 1'b0; bb.wr_data0 = '0;
    bb.req1 = 1'b0; bb.addr1 = '0; bb.wr_ena1 = 1'b0; bb.wr_data1 = '0;
    cont_seq = 10'b00_1111_0000;
    gap_seq  = 6'b00_1111;

    // Reset with port 0 already requesting; preload DMEM[0x10]
    ba.req0 = 1'b1; ba.addr0 = 32'h10;
    next_cyc();
    pl_we = 1'b1; pl_addr = 8'h10; pl_data = 32'hDEAD_BEEF;
    #1;
    chk("rst_gnt0", ba.gnt0, 0);
    chk("rst_gnt1", ba.gnt1, 0);
    chk("rst_rd_valid0", ba.rd_valid0, 0);
    chk("rst_rd_valid1", ba.rd_valid1, 0);
    chk("rst_mem_wr_ena", ba.mem_wr_ena, 0);
    chk("rst_mem_addr", ba.mem_addr, 0);
    chk("rst_rd_data0", ba.rd_data0, 0);
    next_cyc();
    pl_we = 1'b0;

    // Solo read, granted on the first cycle after reset
    rst = 1'b0; rst_b = 1'b0;
    #1;
    chk("solo_gnt0", ba.gnt0, 1);
    chk("solo_gnt1", ba.gnt1, 0);
    chk("solo_mem_addr", ba.mem_addr, 32'h10);
    chk("solo_mem_wr_ena", ba.mem_wr_ena, 0);
    next_cyc();
    ba.req0 = 1'b0;
    #1;
    chk("solo_rd_valid0", ba.rd_valid0, 1);
    chk("solo_rd_data0", ba.rd_data0, 32'hDEAD_BEEF);
    chk("solo_rd_valid1", ba.rd_valid1, 0);
    chk("solo_rd_data1", ba.rd_data1, 0);
    chk("idle_gnt0", ba.gnt0, 0);
    chk("idle_mem_addr", ba.mem_addr, 0);
    next_cyc();

    // Port 1 write, then port 0 reads it back
    ba.req1 = 1'b1; ba.addr1 = 32'h20; ba.wr_data1 = 32'h1234_5678; ba.wr_ena1 = 1'b1;
    #1;
    chk("wr_gnt1", ba.gnt1, 1);
    chk("wr_gnt0", ba.gnt0, 0);
    chk("wr_mem_wr_ena", ba.mem_wr_ena, 1);
    chk("wr_mem_addr", ba.mem_addr, 32'h20);
    chk("wr_mem_wr_data", ba.mem_wr_data, 32'h1234_5678);
    next_cyc();
    ba.req1 = 1'b0; ba.wr_ena1 = 1'b0;
    ba.req0 = 1'b1; ba.addr0 = 32'h20;
    #1;
    chk("wr_no_valid0", ba.rd_valid0, 0);
    chk("wr_no_valid1", ba.rd_valid1, 0);
    chk("rb_gnt0", ba.gnt0, 1);
    chk("rb_mem_wr_ena", ba.mem_wr_ena, 0);
    next_cyc();
    ba.req0 = 1'b0;
    #1;
    chk("rb_rd_valid0", ba.rd_valid0, 1);
    chk("rb_rd_data0", ba.rd_data0, 32'h1234_5678);
    next_cyc();

    // Continuous contention, reads on both ports
    ba.req0 = 1'b1; ba.addr0 = 32'h10;
    ba.req1 = 1'b1; ba.addr1 = 32'h20;
    pg0 = 1'b0; pg1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("cont_gnt0_%0d", i), ba.gnt0, !cont_seq[i]);
      chk($sformatf("cont_gnt1_%0d", i), ba.gnt1, cont_seq[i]);
      chk($sformatf("cont_vld0_%0d", i), ba.rd_valid0, pg0);
      chk($sformatf("cont_vld1_%0d", i), ba.rd_valid1, pg1);
      chk($sformatf("cont_dat0_%0d", i), ba.rd_data0, pg0 ? 32'hDEAD_BEEF : 32'h0);
      chk($sformatf("cont_dat1_%0d", i), ba.rd_data1, pg1 ? 32'h1234_5678 : 32'h0);
      pg0 = !cont_seq[i];
      pg1 = cont_seq[i];
      next_cyc();
    end
    ba.req0 = 1'b0; ba.req1 = 1'b0;
    #1;
    chk("cont_tail_vld0", ba.rd_valid0, 1);
    chk("cont_tail_vld1", ba.rd_valid1, 0);
    chk("cont_tail_gnt", {ba.gnt1, ba.gnt0}, 0);
    next_cyc();

    // Idle gap: port 1 keeps ownership across an idle cycle, burst restarts
    ba.req1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("gap_solo_gnt1_%0d", i), ba.gnt1, 1);
      next_cyc();
    end
    ba.req1 = 1'b0;
    #1;
    chk("gap_idle_gnt", {ba.gnt1, ba.gnt0}, 0);
    chk("gap_idle_wr_ena", ba.mem_wr_ena, 0);
    next_cyc();
    ba.req0 = 1'b1; ba.req1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("gap_gnt1_%0d", i), ba.gnt1, gap_seq[i]);
      chk($sformatf("gap_gnt0_%0d", i), ba.gnt0, !gap_seq[i]);
      next_cyc();
    end
    ba.req0 = 1'b0; ba.req1 = 1'b0;
    next_cyc();

    // Statistics over 10 cycles of full contention after a fresh reset
    rst = 1'b1;
    #1;
    chk("stat_rst_conf", ba.stat_conflict, 0);
    chk("stat_rst_g0", ba.stat_gnt0, 0);
    next_cyc();
    rst = 1'b0;
    ba.req0 = 1'b1; ba.req1 = 1'b1;
    repeat (10) next_cyc();
    ba.req0 = 1'b0; ba.req1 = 1'b0;
`ifdef MIPS_MEM_ARB_STATS_EN
    exp_conf = 32'd10; exp_g0 = 32'd6; exp_g1 = 32'd4;
`else
    exp_conf = 32'd0;  exp_g0 = 32'd0; exp_g1 = 32'd0;
`endif
    #1;
    chk("stat_conflict", ba.stat_conflict, exp_conf);
    chk("stat_gnt0", ba.stat_gnt0, exp_g0);
    chk("stat_gnt1", ba.stat_gnt1, exp_g1);
    chk("stat_gnt_sum", ba.stat_gnt0 + ba.stat_gnt1, exp_g0 + exp_g1);
    next_cyc();

    // Reset mid-read on the RD_LATENCY=3 instance
    bb.req0 = 1'b1; bb.addr0 = 32'h10;
    #1;
    chk("rmr_gnt0", bb.gnt0, 1);
    next_cyc();
    rst_b = 1'b1;
    bb.req1 = 1'b1; bb.addr1 = 32'h24;
    #1;
    chk("rmr_rst_vld0", bb.rd_valid0, 0);
    chk("rmr_rst_gnt0", bb.gnt0, 0);
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      #1;
      chk($sformatf("rmr_hold_vld0_%0d", i), bb.rd_valid0, 0);
      chk($sformatf("rmr_hold_vld1_%0d", i), bb.rd_valid1, 0);
    end
    next_cyc();
    rst_b = 1'b0;
    #1;
    chk("rmr_post_gnt0", bb.gnt0, 1);
    chk("rmr_post_gnt1", bb.gnt1, 0);
    chk("rmr_post_vld0", bb.rd_valid0, 0);
    next_cyc();
    bb.req0 = 1'b0; bb.req1 = 1'b0;
    #1;
    chk("rmr_p1_vld0", bb.rd_valid0, 0);
    next_cyc();
    #1;
    chk("rmr_p2_vld0", bb.rd_valid0, 0);
    next_cyc();
    #1;
    chk("rmr_p3_vld0", bb.rd_valid0, 1);
    chk("rmr_p3_dat0", bb.rd_data0, 32'hCAFE_F00D);
    chk("rmr_p3_vld1", bb.rd_valid1, 0);
    next_cyc();
    #1;
    chk("rmr_p4_vld0", bb.rd_valid0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
